decimal_entry_converter: RTL

DECIMAL_ENTRY_CONVERTER -- requirements
Module: decimal_entry_converter

---
 rtl/decimal_entry_converter_pkg.sv | 52 +++++
 rtl/decimal_entry_converter_bcd_digit_sub3.sv | 14 +
 rtl/decimal_entry_converter.sv | 100 ++++++++++
 3 files changed

// File: rtl/decimal_entry_converter_pkg.sv
// Shared types and constants for the signed three-digit BCD entry converter.
// Also holds the range/saturation rule applied to the finished binary magnitude.
package decimal_entry_converter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_t;

  localparam int unsigned ITER_DEFAULT    = 12;
  localparam logic [3:0]  BCD_MAX         = 4'd9;
  localparam logic [11:0] NUM_POS_MAX     = 12'd127;
  localparam logic [11:0] NUM_NEG_MAG_MAX = 12'd128;
  localparam logic [7:0]  SAT_POS         = 8'h7F;
  localparam logic [7:0]  SAT_NEG         = 8'h80;

  typedef struct packed {
    logic [7:0] num;
    logic       err;
  } result_t;

  function automatic logic digit_invalid(input logic [3:0] d);
    return d > BCD_MAX;
  endfunction

  // The range check sees the full 12-bit magnitude; only in-range values are narrowed.
  function automatic result_t saturate(input logic neg, input logic inv, input logic [11:0] mag);
    result_t r;
    r.num = 8'h00;
    r.err = 1'b0;
    if (inv) begin
      r.err = 1'b1;
    end else if (!neg) begin
      if (mag > NUM_POS_MAX) begin
        r.num = SAT_POS;
        r.err = 1'b1;
      end else begin
        r.num = mag[7:0];
      end
    end else begin
      if (mag > NUM_NEG_MAG_MAX) begin
        r.num = SAT_NEG;
        r.err = 1'b1;
      end else begin
        r.num = 8'h00 - mag[7:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/decimal_entry_converter_bcd_digit_sub3.sv
// Reverse double-dabble correction for one BCD digit: subtract 3 when the digit is >= 8.
module bcd_digit_sub3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  always_comb begin
    dout = din;
    if (din >= 4'd8) begin
      dout = din - 4'd3;
    end
  end

endmodule

// File: rtl/decimal_entry_converter.sv
// Converts a signed three-digit BCD entry to an 8-bit two's-complement value with
// saturation and error flag; fixed latency of ITER+1 cycles after the start edge.
module decimal_entry_converter
  import decimal_entry_converter_pkg::*;
#(
  parameter int unsigned ITER = ITER_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       neg,
  input  logic [3:0] hundreds,
  input  logic [3:0] tens,
  input  logic [3:0] ones,
  output logic       busy,
  output logic       done,
  output logic [7:0] num,
  output logic       err
);

  localparam int unsigned CntW = $clog2(ITER + 1);

  state_t          state;
  logic [CntW-1:0] cnt;
  logic [11:0]     bcd;
  logic [11:0]     bin;
  logic            neg_q;
  logic            inv_q;

  logic [23:0]     shifted;
  logic [11:0]     bcd_adj;
  result_t         res;

  assign shifted = {bcd, bin} >> 1;

  bcd_digit_sub3 u_sub3_ones (
    .din  (shifted[15:12]),
    .dout (bcd_adj[3:0])
  );

  bcd_digit_sub3 u_sub3_tens (
    .din  (shifted[19:16]),
    .dout (bcd_adj[7:4])
  );

  bcd_digit_sub3 u_sub3_hundreds (
    .din  (shifted[23:20]),
    .dout (bcd_adj[11:8])
  );

  assign res = saturate(neg_q, inv_q, bin);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      bcd   <= '0;
      bin   <= '0;
      neg_q <= 1'b0;
      inv_q <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      num   <= 8'h00;
      err   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            bcd   <= {hundreds, tens, ones};
            bin   <= '0;
            neg_q <= neg;
            inv_q <= digit_invalid(hundreds) | digit_invalid(tens) | digit_invalid(ones);
            cnt   <= CntW'(ITER);
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          bcd <= bcd_adj;
          bin <= shifted[11:0];
          cnt <= cnt - 1'b1;
          // Leave after the ITER-th shift, i.e. as the counter steps to zero.
          if (cnt == CntW'(1)) begin
            state <= FINISH;
          end
        end
        FINISH: begin
          num   <= res.num;
          err   <= res.err;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
